// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the floating-point add/sub pipeline scheduler.
package fp_sched_pkg;

    localparam int unsigned EXP_W  = 8;
    localparam int unsigned MANT_W = 23;
    localparam int unsigned FP_W   = 1 + EXP_W + MANT_W;

    localparam logic [FP_W-1:0] FP_ZERO = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_CLEAR = 2'd3
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or above ptr, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  grant,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    int unsigned pos;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NREQ) pos = pos - NREQ;
            if (!found && req[IDX_W'(pos)]) begin
                found = 1'b1;
                idx   = IDX_W'(pos);
            end
        end
        if (found) grant[idx] = 1'b1;
    end

endmodule

// File: rtl/fp_addsub_sched.sv
// Round-robin scheduler sharing one FP add/sub pipeline between NREQ requesters,
// with a per-operation timeout and a one-cycle result-consumed clear.
module fp_addsub_sched
    import fp_sched_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned N    = 32,
    parameter int unsigned TMO  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*N-1:0] req_a,
    input  logic [NREQ*N-1:0] req_b,
    input  logic [NREQ-1:0]   req_sub,
    output logic              dp_valid,
    output logic [N-1:0]      dp_a,
    output logic [N-1:0]      dp_b,
    output logic              dp_sub,
    input  logic              dp_done,
    input  logic [N-1:0]      dp_result,
    output logic              dp_clear,
    output logic [NREQ-1:0]   resp_valid,
    input  logic [NREQ-1:0]   resp_ready,
    output logic [N-1:0]      resp_data,
    output logic              resp_tmo,
    output logic              busy,
    output logic [15:0]       op_count
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(TMO);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [NREQ-1:0]   grant;
    logic [IDX_W-1:0]  gidx;
    logic              gfound;

    logic              dp_valid_d, dp_sub_d, dp_clear_d, resp_tmo_d;
    logic [N-1:0]      dp_a_d, dp_b_d, resp_data_d;
    logic [NREQ-1:0]   resp_valid_d;
    logic [15:0]       op_count_d;

    rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_arb (
        .req   (req_valid),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (gidx),
        .found (gfound)
    );

    // Accept is combinational and only offered from IDLE, never while in reset.
    assign req_ready = (rst_n && state_q == ST_IDLE) ? grant : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (gfound) state_d = ST_WAIT;
            ST_WAIT:  if (dp_done || cnt_q == CNT_W'(TMO - 1)) state_d = ST_RESP;
            ST_RESP:  if (resp_ready[owner_q]) state_d = ST_CLEAR;
            ST_CLEAR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        owner_d      = owner_q;
        ptr_d        = ptr_q;
        cnt_d        = cnt_q;
        dp_valid_d   = dp_valid;
        dp_a_d       = dp_a;
        dp_b_d       = dp_b;
        dp_sub_d     = dp_sub;
        dp_clear_d   = dp_clear;
        resp_valid_d = resp_valid;
        resp_data_d  = resp_data;
        resp_tmo_d   = resp_tmo;
        op_count_d   = op_count;
        unique case (state_q)
            ST_IDLE: if (gfound) begin
                dp_a_d     = req_a[32'(gidx) * N +: N];
                dp_b_d     = req_b[32'(gidx) * N +: N];
                dp_sub_d   = req_sub[gidx];
                owner_d    = gidx;
                ptr_d      = IDX_W'((32'(gidx) + 1) % NREQ);
                cnt_d      = '0;
                dp_valid_d = 1'b1;
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // A result arriving on the timeout cycle still wins.
                if (dp_done) begin
                    resp_data_d           = dp_result;
                    resp_tmo_d            = 1'b0;
                    resp_valid_d          = '0;
                    resp_valid_d[owner_q] = 1'b1;
                    dp_valid_d            = 1'b0;
                end else if (cnt_q == CNT_W'(TMO - 1)) begin
                    resp_data_d           = N'(FP_ZERO);
                    resp_tmo_d            = 1'b1;
                    resp_valid_d          = '0;
                    resp_valid_d[owner_q] = 1'b1;
                    dp_valid_d            = 1'b0;
                end
            end
            ST_RESP: if (resp_ready[owner_q]) begin
                resp_valid_d = '0;
                resp_tmo_d   = 1'b0;
                dp_clear_d   = 1'b1;
                if (op_count != 16'hFFFF) op_count_d = op_count + 16'd1;
            end
            ST_CLEAR: dp_clear_d = 1'b0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_q    <= '0;
            ptr_q      <= '0;
            cnt_q      <= '0;
            dp_valid   <= 1'b0;
            dp_a       <= '0;
            dp_b       <= '0;
            dp_sub     <= 1'b0;
            dp_clear   <= 1'b0;
            resp_valid <= '0;
            resp_data  <= '0;
            resp_tmo   <= 1'b0;
            op_count   <= '0;
            busy       <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            dp_valid   <= dp_valid_d;
            dp_a       <= dp_a_d;
            dp_b       <= dp_b_d;
            dp_sub     <= dp_sub_d;
            dp_clear   <= dp_clear_d;
            resp_valid <= resp_valid_d;
            resp_data  <= resp_data_d;
            resp_tmo   <= resp_tmo_d;
            op_count   <= op_count_d;
            busy       <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fp_addsub_sched.sv
// Self-checking bench for fp_addsub_sched: directed table, random ops, reset and saturation corners.
module tb_fp_addsub_sched;

    localparam int NREQ = 2;
    localparam int N    = 32;
    localparam int TMO  = 16;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ-1:0]   req_sub;
    logic              dp_valid;
    logic [N-1:0]      dp_a;
    logic [N-1:0]      dp_b;
    logic              dp_sub;
    logic              dp_done;
    logic [N-1:0]      dp_result;
    logic              dp_clear;
    logic [NREQ-1:0]   resp_valid;
    logic [NREQ-1:0]   resp_ready;
    logic [N-1:0]      resp_data;
    logic              resp_tmo;
    logic              busy;
    logic [15:0]       op_count;

    fp_addsub_sched #(.NREQ(NREQ), .N(N), .TMO(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_sub    (req_sub),
        .dp_valid   (dp_valid),
        .dp_a       (dp_a),
        .dp_b       (dp_b),
        .dp_sub     (dp_sub),
        .dp_done    (dp_done),
        .dp_result  (dp_result),
        .dp_clear   (dp_clear),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_tmo   (resp_tmo),
        .busy       (busy),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int mptr = 0;
    logic [15:0] mcount = 16'd0;

    typedef struct {
        logic [1:0]  mask;
        logic [31:0] a0, b0, a1, b1;
        logic        s0, s1;
        int          lat;
        int          rdly;
        logic [31:0] res;
        int          exp_grant;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model arbitration: first requester with valid set, from the pointer upward, wrapping.
    function automatic int model_grant(input logic [1:0] mask);
        for (int i = 0; i < NREQ; i++) begin
            if (mask[(mptr + i) % NREQ]) return (mptr + i) % NREQ;
        end
        return -1;
    endfunction

    // Runs one full operation starting at a negedge with the DUT idle.
    // lat = cycle (after transfer) on which dp_done is offered; outside 1..TMO means never.
    task automatic do_op(input vec_t v);
        int          g;
        int          exp_at;
        logic [31:0] ea, eb, exp_data;
        logic        es, tmo;
        logic [1:0]  ohot;
        bit          ok;
        g = (v.exp_grant >= 0) ? v.exp_grant : model_grant(v.mask);
        mptr = (g + 1) % NREQ;
        ohot = 2'(1 << g);
        ea = (g == 0) ? v.a0 : v.a1;
        eb = (g == 0) ? v.b0 : v.b1;
        es = (g == 0) ? v.s0 : v.s1;
        tmo = !(v.lat >= 1 && v.lat <= TMO);
        exp_at = tmo ? TMO + 1 : v.lat + 1;
        exp_data = tmo ? 32'h0 : v.res;

        req_a = {v.a1, v.a0};
        req_b = {v.b1, v.b0};
        req_sub = {v.s1, v.s0};
        req_valid = v.mask;
        resp_ready = '0;
        dp_done = 1'b0;
        #1;
        chk("grant", 64'(req_ready), 64'(ohot));
        chk("idle_busy", 64'(busy), 64'd0);

        @(negedge clk);
        req_a = {$urandom, $urandom};
        req_b = {$urandom, $urandom};
        req_sub = 2'($urandom);
        chk("dp_operands", {dp_a, dp_b}, {ea, eb});
        chk("dp_ctrl", {61'd0, dp_valid, dp_sub, busy}, {61'd0, 1'b1, es, 1'b1});

        ok = 1'b1;
        for (int j = 1; j < exp_at; j++) begin
            if (resp_valid !== 2'b00 || req_ready !== 2'b00 || dp_valid !== 1'b1 ||
                dp_a !== ea || dp_b !== eb || busy !== 1'b1) ok = 1'b0;
            dp_done = (j == v.lat);
            dp_result = (j == v.lat) ? v.res : $urandom;
            @(negedge clk);
        end
        chk("wait_phase", 64'(ok), 64'd1);
        dp_done = 1'b0;

        chk("resp_valid", 64'(resp_valid), 64'(ohot));
        chk("resp_data", 64'(resp_data), 64'(exp_data));
        chk("resp_tmo_dpv", {62'd0, resp_tmo, dp_valid}, {62'd0, tmo, 1'b0});

        ok = 1'b1;
        for (int k = 0; k < v.rdly; k++) begin
            resp_ready = ~ohot;
            dp_done = 1'($urandom);
            dp_result = $urandom;
            @(negedge clk);
            if (resp_valid !== ohot || resp_data !== exp_data || resp_tmo !== tmo ||
                dp_clear !== 1'b0 || req_ready !== 2'b00 || busy !== 1'b1 ||
                op_count !== mcount) ok = 1'b0;
        end
        if (v.rdly > 0) chk("backpressure", 64'(ok), 64'd1);

        resp_ready = ohot;
        dp_done = 1'b0;
        @(negedge clk);
        mcount = (mcount == 16'hFFFF) ? 16'hFFFF : mcount + 16'd1;
        chk("clear_pulse", {61'd0, dp_clear, resp_tmo, busy}, {61'd0, 1'b1, 1'b0, 1'b1});
        chk("resp_dropped", 64'(resp_valid), 64'd0);
        chk("op_count", 64'(op_count), 64'(mcount));
        chk("no_ready_clear", 64'(req_ready), 64'd0);

        resp_ready = '0;
        @(negedge clk);
        chk("back_idle", {62'd0, dp_clear, busy}, 64'd0);
        req_valid = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t rv;
        rst_n = 1'b0;
        req_valid = 2'b11;
        req_a = '0; req_b = '0; req_sub = '0;
        dp_done = 1'b0; dp_result = '0; resp_ready = '0;
        #12;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_dp", {dp_valid, dp_sub, dp_clear, dp_a}, 64'd0);
        chk("rst_dp_b", 64'(dp_b), 64'd0);
        chk("rst_resp", {resp_valid, resp_tmo, busy, resp_data}, 64'd0);
        chk("rst_count", 64'(op_count), 64'd0);
        @(negedge clk);
        req_valid = '0;
        rst_n = 1'b1;
        @(negedge clk);

        // mask, a0, b0, a1, b1, s0, s1, lat, rdly, res, grant
        tbl[0] = '{2'b01, 32'h3F800000, 32'h40000000, 32'h0, 32'h0, 1'b0, 1'b0, 3, 0, 32'h40400000, 0};
        tbl[1] = '{2'b10, 32'h0, 32'h0, 32'h40A00000, 32'h3F800000, 1'b0, 1'b1, 4, 1, 32'h40800000, 1};
        tbl[2] = '{2'b11, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b0, 1'b1, 2, 0, 32'hA0A0A0A0, 0};
        tbl[3] = '{2'b11, 32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888, 1'b1, 1'b0, 5, 2, 32'hB1B1B1B1, 1};
        tbl[4] = '{2'b11, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 1'b0, 1'b0, 1, 0, 32'hC2C2C2C2, 0};
        tbl[5] = '{2'b11, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'h12345678, 32'h9ABCDEF0, 1'b1, 1'b1, 7, 1, 32'hD3D3D3D3, 1};
        tbl[6] = '{2'b01, 32'h40490FDB, 32'h402DF854, 32'h0, 32'h0, 1'b1, 1'b0, 0, 0, 32'hDEADBEEF, 0};
        tbl[7] = '{2'b10, 32'h0, 32'h0, 32'hC0000000, 32'h3F000000, 1'b0, 1'b0, 16, 0, 32'hBFC00000, 1};
        tbl[8] = '{2'b10, 32'h0, 32'h0, 32'h41200000, 32'h41200000, 1'b0, 1'b1, 5, 10, 32'h00000000, 1};
        tbl[9] = '{2'b11, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 1'b1, 1'b0, 17, 0, 32'hFFFFFFFF, 0};
        for (int i = 0; i < 10; i++) do_op(tbl[i]);

        for (int i = 0; i < 24; i++) begin
            rv.mask = 2'($urandom_range(1, 3));
            rv.a0 = $urandom; rv.b0 = $urandom; rv.a1 = $urandom; rv.b1 = $urandom;
            rv.s0 = 1'($urandom); rv.s1 = 1'($urandom);
            rv.lat = $urandom_range(1, 19);
            rv.rdly = $urandom_range(0, 3);
            rv.res = $urandom;
            rv.exp_grant = -1;
            do_op(rv);
        end

        // Reset while an operation is in WAIT: abandoned, pointer returns to 0.
        req_valid = 2'b01;
        req_a = {32'h0, 32'h12121212};
        @(negedge clk);
        chk("rst_op_started", 64'(dp_valid), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_wait", {60'd0, dp_valid, busy, req_ready}, 64'd0);
        chk("rst_mid_resp", {resp_valid, op_count}, 64'd0);
        mptr = 0;
        mcount = 16'd0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rv = '{2'b11, 32'h01010101, 32'h02020202, 32'h03030303, 32'h04040404, 1'b0, 1'b0, 2, 0, 32'h05050505, 0};
        do_op(rv);

        // Preload the completion counter just below saturation.
        force dut.op_count = 16'hFFFE;
        #1;
        release dut.op_count;
        mcount = 16'hFFFE;
        rv = '{2'b01, 32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 1'b0, 1'b0, 2, 0, 32'h40000000, -1};
        do_op(rv);
        rv.lat = 0;
        do_op(rv);
        chk("saturated", 64'(op_count), 64'hFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fp_addsub_sched.md
Name: fp_addsub_sched

Overview:
- Round-robin scheduler that shares the single floating-point add/subtract pipeline (align → add → normalize → round) between NREQ requesters.
- Accepts one operation at a time and drives the pipeline input valid and operands.
- Waits for the rounding stage's valid, which arrives after a variable number of cycles because of the round-up re-normalize pass.
- Returns the result to the owning requester, then pulses the pipeline's result-consumed clear.

Parameters:
- NREQ, 2, number of requesters (2..8).
- N, 32, operand/result width (IEEE single).
- TMO, 16, cycles in WAIT before abandoning an operation (≥4).

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  one-hot accept; a transfer happens when req_valid[i] && req_ready[i].
- req_a  in  NREQ*N  operand A per requester (slice i = [i*N +: N]).
- req_b  in  NREQ*N  operand B per requester.
- req_sub  in  NREQ  1 = subtract.
- dp_valid  out  1  drives pipeline validInput.
- dp_a, dp_b  out  N  operands to pipeline.
- dp_sub  out  1  subCtrl to pipeline.
- dp_done  in  1  rounding-stage valid.
- dp_result  in  N  packed {sign, exp, mant} from rounding stage.
- dp_clear  out  1  drives pipeline ResultValid (consumes result).
- resp_valid  out  NREQ  one-hot result valid.
- resp_ready  in  NREQ  requester accepts result.
- resp_data  out  N  result; shared by all requesters.
- resp_tmo  out  1  qualifies resp_valid: operation timed out, resp_data = 0.
- busy  out  1  state != IDLE.
- op_count  out  16  completed operations, saturating at 16'hFFFF.

Behaviour:
- Reset (async, Reset_n low):
  - State = IDLE; rr pointer = 0; wait counter = 0.
  - Outputs zero: dp_valid, dp_a, dp_b, dp_sub, dp_clear, resp_valid, resp_data, resp_tmo, op_count.
  - req_ready = 0 while in reset.
  - Reset mid-operation abandons the operation silently; there is no response.
- FSM states: IDLE, WAIT, RESP, CLEAR.
- IDLE:
  - Grant = first requester with req_valid set, searching from rr pointer upward and wrapping modulo NREQ.
  - req_ready is combinational: one-hot on the grant, and only in IDLE.
  - On transfer:
    - Register operands into dp_a/dp_b/dp_sub.
    - owner ← grant; rr pointer ← (grant+1) mod NREQ; counter ← 0.
    - dp_valid ← 1; go to WAIT.
  - No request: stay; pointer unchanged.
- WAIT:
  - dp_valid held 1; operands stable; counter increments each cycle.
  - dp_done=1: resp_data ← dp_result; resp_tmo ← 0; resp_valid[owner] ← 1; go to RESP.
  - Otherwise, counter == TMO-1: resp_data ← 0; resp_tmo ← 1; resp_valid[owner] ← 1; go to RESP.
  - dp_done in the same cycle as the timeout: done wins.
- RESP:
  - dp_valid ← 0; resp_valid/resp_data/resp_tmo held.
  - resp_ready[owner]: clear resp_valid and resp_tmo; dp_clear ← 1; op_count += 1 (saturating; timeouts count); go to CLEAR.
  - resp_ready from non-owners is ignored.
- CLEAR:
  - dp_clear high for exactly this one cycle; then dp_clear ← 0; go to IDLE.
  - req_ready stays 0 in CLEAR, so the minimum spacing between grants is 4 cycles plus pipeline latency.
- dp_done outside WAIT is ignored.
- Request latency: result visible on resp_valid the cycle after dp_done is sampled.
- A requester's req_valid dropped before grant is not an error. Its operands are only sampled on transfer.

Decomposition:
- Package fp_sched_pkg:
  - state enum (IDLE, WAIT, RESP, CLEAR);
  - FP field widths (EXP_W=8, MANT_W=23);
  - the zero-result constant.
- One sub-module, rr_arbiter: combinational NREQ-wide round-robin grant from a request vector and pointer, returning one-hot grant plus index. It is reusable by the normalizer share logic.
- Everything else stays in fp_addsub_sched.

Test Plan:
1. Single request: req_valid[0]=1, a=32'h3F800000, b=32'h40000000, sub=0; model dp_done 3 cycles after dp_valid with 32'h40400000. Expect:
   - req_ready[0] one cycle;
   - resp_valid[0] with resp_data=32'h40400000;
   - dp_clear one pulse after resp_ready;
   - op_count=1.
2. Contention: req_valid=2'b11 held for 4 operations. Expect grants 0,1,0,1, and no req_ready while busy=1.
3. Timeout: dp_done never asserts, TMO=16. Expect resp_valid[owner] 16 cycles after grant, resp_tmo=1, resp_data=0, op_count incremented.
4. Backpressure: hold resp_ready[1]=0 for 10 cycles while resp_ready[0]=1. Expect resp_valid[1] and resp_data stable, dp_clear=0, and no new grant until release.
5. Reset mid-WAIT: drop Reset_n asynchronously between clock edges. Expect dp_valid=0 and busy=0 immediately; no response; the next grant goes to requester 0.
6. Saturation: preload via 65535 ops (or force); one more op. Expect op_count stays 16'hFFFF.
